// File: rtl/ro_heater_ctrl.sv
// Banked ring-oscillator heater controller: staged bank enable/disable, PWM duty
// modulation while running, and a gated edge counter on one sense RO.
module ro_heater_ctrl #(
  parameter int NUM_BANKS   = 8,
  parameter int RAMP_CYCLES = 1024,
  parameter int PWM_PERIOD  = 256,
  parameter int DUTY_W      = 9,
  parameter int GATE_CYCLES = 65536,
  parameter int CNT_W       = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_BANKS-1:0] bank_mask,
  input  logic [DUTY_W-1:0]    duty,
  input  logic                 ro_sense,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 busy,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     freq_count,
  output logic                 freq_valid
);

  localparam int TW = (RAMP_CYCLES > 2) ? $clog2(RAMP_CYCLES) : 1;
  localparam int PW = (PWM_PERIOD  > 2) ? $clog2(PWM_PERIOD)  : 1;
  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t               state_q;
  logic [NUM_BANKS-1:0] stage_q;
  logic [NUM_BANKS-1:0] mask_q;
  logic [TW-1:0]        timer_q;
  logic [PW-1:0]        pwm_q;

  logic [NUM_BANKS-1:0] avail;
  logic [NUM_BANKS-1:0] low_bit;
  logic [NUM_BANKS-1:0] hi_bit;
  logic [NUM_BANKS-1:0] stage_up_d;
  logic [NUM_BANKS-1:0] stage_dn_d;
  logic                 ramp_last;
  logic                 pwm_last;
  logic [DUTY_W-1:0]    pwm_ext;
  logic                 gate;

  // Next bank to add is the lowest unstaged masked bank; removal takes the highest.
  always_comb begin
    avail      = mask_q & ~stage_q;
    low_bit    = avail & (~avail + NUM_BANKS'(1));
    hi_bit     = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (stage_q[i]) begin
        hi_bit    = '0;
        hi_bit[i] = 1'b1;
      end
    end
    stage_up_d = stage_q | low_bit;
    stage_dn_d = stage_q & ~hi_bit;
  end

  assign ramp_last = (timer_q == TW'(RAMP_CYCLES - 1));
  assign pwm_last  = (pwm_q == PW'(PWM_PERIOD - 1));
  assign pwm_ext   = DUTY_W'(pwm_q);

  // Staging runs at full on; only RUN modulates.
  assign gate    = (state_q != RUN) || (pwm_ext < duty);
  assign bank_en = stage_q & {NUM_BANKS{gate}};
  assign busy    = (state_q != IDLE);
  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      pwm_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (|bank_mask)) begin
            state_q <= RAMP_UP;
            mask_q  <= bank_mask;
            timer_q <= '0;
          end
        end
        RAMP_UP: begin
          if (!start) begin
            state_q <= RAMP_DOWN;
            timer_q <= '0;
          end else if (ramp_last) begin
            timer_q <= '0;
            stage_q <= stage_up_d;
            if (stage_up_d == mask_q) begin
              state_q <= RUN;
              pwm_q   <= '0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RUN: begin
          pwm_q <= pwm_last ? '0 : pwm_q + PW'(1);
          if (!start) begin
            state_q <= RAMP_DOWN;
            timer_q <= '0;
          end
        end
        RAMP_DOWN: begin
          if (stage_q == '0) begin
            state_q <= IDLE;
          end else if (ramp_last) begin
            timer_q <= '0;
            stage_q <= stage_dn_d;
            if (stage_dn_d == '0) state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frequency monitor: sync1/sync2 resynchronize, sync3 delays for edge detect.
  logic             sync1_q, sync2_q, sync3_q;
  logic [GW-1:0]    win_q;
  logic [CNT_W-1:0] edge_q;
  logic [CNT_W-1:0] freq_cnt_q;
  logic             freq_vld_q;
  logic             edge_det;
  logic             win_last;
  logic [CNT_W-1:0] edge_d;

  assign edge_det = sync2_q & ~sync3_q;
  assign win_last = (win_q == GW'(GATE_CYCLES - 1));
  assign edge_d   = (edge_det && (edge_q != {CNT_W{1'b1}})) ? edge_q + CNT_W'(1) : edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      win_q      <= '0;
      edge_q     <= '0;
      freq_cnt_q <= '0;
      freq_vld_q <= 1'b0;
    end else begin
      sync1_q <= ro_sense;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (win_last) begin
        win_q      <= '0;
        freq_cnt_q <= edge_d;
        freq_vld_q <= 1'b1;
        edge_q     <= '0;
      end else begin
        win_q      <= win_q + GW'(1);
        edge_q     <= edge_d;
        freq_vld_q <= 1'b0;
      end
    end
  end

  assign freq_count = freq_cnt_q;
  assign freq_valid = freq_vld_q;

endmodule

// File: tb/tb_ro_heater_ctrl.sv
// Scoreboard bench for ro_heater_ctrl: stimulus pushes per-cycle expectations,
// a single negedge monitor pops and compares bank/state and frequency outputs.
module tb_ro_heater_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mask = 4'b1011;
  logic [3:0] duty = 4'd3;
  logic       ro = 1'b0;
  logic       ro2 = 1'b0;

  logic [3:0] bank_en;
  logic       busy;
  logic [1:0] state_o;
  logic [7:0] freq_count;
  logic       freq_valid;

  logic       s2 = 1'b0;
  logic [3:0] m2 = 4'b0000;
  logic [3:0] d2 = 4'd0;
  logic [3:0] be2;
  logic       busy2;
  logic [1:0] st2;
  logic [2:0] fc2;
  logic       fv2;

  ro_heater_ctrl #(.NUM_BANKS(4), .RAMP_CYCLES(4), .PWM_PERIOD(8), .DUTY_W(4),
                   .GATE_CYCLES(100), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bank_mask(mask), .duty(duty),
    .ro_sense(ro), .bank_en(bank_en), .busy(busy), .state_o(state_o),
    .freq_count(freq_count), .freq_valid(freq_valid));

  ro_heater_ctrl #(.NUM_BANKS(4), .RAMP_CYCLES(4), .PWM_PERIOD(8), .DUTY_W(4),
                   .GATE_CYCLES(100), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(s2), .bank_mask(m2), .duty(d2),
    .ro_sense(ro2), .bank_en(be2), .busy(busy2), .state_o(st2),
    .freq_count(fc2), .freq_valid(fv2));

  always #5 clk = ~clk;
  initial begin #2; forever #50 ro = ~ro; end
  initial begin #2; forever #25 ro2 = ~ro2; end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] be;
    logic [1:0] st;
    logic       busy;
    logic       f;
  } exp_t;

  typedef struct {
    int v;
    int tol;
  } fexp_t;

  exp_t  sb[$];
  fexp_t fq[$];
  int    sq[$];
  int    errors = 0;
  int    checks = 0;
  int    last_fv = -1;
  bit    done = 1'b0;

  localparam logic [3:0] B = 4'b1011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_k(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expr(input int base, input int k0, input int k1,
                      input logic [3:0] be, input logic [1:0] st);
    for (int k = k0; k <= k1; k++)
      sb.push_back('{cyc: base + k, be: be, st: st, busy: (st != 2'd0), f: 1'b0});
  endtask

  always @(negedge clk) begin
    exp_t  e;
    fexp_t f;
    int    sv;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL stale cyc=%0d: expectation never compared", e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (bank_en !== e.be || state_o !== e.st || busy !== e.busy) begin
        errors++;
        $display("FAIL bank cyc=%0d got be=%b st=%0d busy=%b want be=%b st=%0d busy=%b",
                 cyc, bank_en, state_o, busy, e.be, e.st, e.busy);
      end
      if (e.f) begin
        checks++;
        if (freq_count !== 8'd0 || freq_valid !== 1'b0) begin
          errors++;
          $display("FAIL freq_reset cyc=%0d got cnt=%0d vld=%b want 0/0",
                   cyc, freq_count, freq_valid);
        end
      end
    end
    if (freq_valid === 1'b1) begin
      if (fq.size() > 0) begin
        f = fq.pop_front();
        checks++;
        if (int'(freq_count) < f.v - f.tol || int'(freq_count) > f.v + f.tol) begin
          errors++;
          $display("FAIL freq_count cyc=%0d got %0d want %0d+-%0d",
                   cyc, freq_count, f.v, f.tol);
        end
        if (f.tol == 0) begin
          checks++;
          if (cyc - last_fv != 100) begin
            errors++;
            $display("FAIL freq_gap cyc=%0d got %0d want 100", cyc, cyc - last_fv);
          end
        end
      end
      last_fv = cyc;
    end
    if (fv2 === 1'b1 && sq.size() > 0) begin
      sv = sq.pop_front();
      checks++;
      if (fc2 !== 3'(sv)) begin
        errors++;
        $display("FAIL freq_sat cyc=%0d got %0d want %0d", cyc, fc2, sv);
      end
    end
    if (done || cyc > 20000) begin
      if (!done) begin
        errors++;
        $display("FAIL timeout cyc=%0d", cyc);
      end
      checks++;
      if (sb.size() + fq.size() + sq.size() != 0) begin
        errors++;
        $display("FAIL leftover got sb=%0d fq=%0d sq=%0d want 0 0 0",
                 sb.size(), fq.size(), sq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    int b, r;
    for (int c = 1; c <= 2; c++)
      sb.push_back('{cyc: c, be: 4'b0000, st: 2'd0, busy: 1'b0, f: 1'b1});
    fq.push_back('{v: 10, tol: 1});
    repeat (4) fq.push_back('{v: 10, tol: 0});
    repeat (3) sq.push_back(7);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full ramp up, PWM at duty 3/0/8, ramp down; mask change and start ignored mid-flight
    b = cyc;
    start = 1'b1;
    expr(b, 0, 0, 4'b0000, 2'd0);
    expr(b, 1, 4, 4'b0000, 2'd1);
    expr(b, 5, 8, 4'b0001, 2'd1);
    expr(b, 9, 12, 4'b0011, 2'd1);
    expr(b, 13, 15, B, 2'd2);
    expr(b, 16, 20, 4'b0000, 2'd2);
    expr(b, 21, 23, B, 2'd2);
    expr(b, 24, 35, 4'b0000, 2'd2);
    expr(b, 37, 44, B, 2'd2);
    expr(b, 45, 48, B, 2'd3);
    expr(b, 49, 52, 4'b0011, 2'd3);
    expr(b, 53, 56, 4'b0001, 2'd3);
    expr(b, 57, 59, 4'b0000, 2'd0);
    to_k(b + 28); duty = 4'd0;
    to_k(b + 30); mask = 4'b0100;
    to_k(b + 36); duty = 4'd8;
    to_k(b + 44); start = 1'b0;
    to_k(b + 50); start = 1'b1;
    to_k(b + 55); start = 1'b0;
    to_k(b + 57); mask = B;
    to_k(b + 60);

    // Stop during ramp-up with two banks staged
    b = cyc;
    start = 1'b1;
    expr(b, 0, 0, 4'b0000, 2'd0);
    expr(b, 1, 4, 4'b0000, 2'd1);
    expr(b, 5, 8, 4'b0001, 2'd1);
    expr(b, 9, 10, 4'b0011, 2'd1);
    expr(b, 11, 14, 4'b0011, 2'd3);
    expr(b, 15, 18, 4'b0001, 2'd3);
    expr(b, 19, 20, 4'b0000, 2'd0);
    to_k(b + 10); start = 1'b0;
    to_k(b + 21);

    // Stop before the first bank step
    b = cyc;
    start = 1'b1;
    expr(b, 0, 0, 4'b0000, 2'd0);
    expr(b, 1, 2, 4'b0000, 2'd1);
    expr(b, 3, 3, 4'b0000, 2'd3);
    expr(b, 4, 5, 4'b0000, 2'd0);
    to_k(b + 2); start = 1'b0;
    to_k(b + 6);

    // Empty mask never leaves IDLE
    b = cyc;
    mask = 4'b0000;
    start = 1'b1;
    expr(b, 0, 5, 4'b0000, 2'd0);
    to_k(b + 5); start = 1'b0; mask = B;
    to_k(b + 6);

    for (int i = 0; i < 1200 && (fq.size() > 0 || sq.size() > 0); i++) tick();

    // Async reset while running at full duty, then a clean ramp-up
    b = cyc;
    start = 1'b1;
    expr(b, 0, 0, 4'b0000, 2'd0);
    expr(b, 1, 4, 4'b0000, 2'd1);
    expr(b, 5, 8, 4'b0001, 2'd1);
    expr(b, 9, 12, 4'b0011, 2'd1);
    expr(b, 13, 14, B, 2'd2);
    to_k(b + 15);
    rst = 1'b1;
    sb.push_back('{cyc: b + 15, be: 4'b0000, st: 2'd0, busy: 1'b0, f: 1'b1});
    to_k(b + 16);
    rst = 1'b0;
    r = b + 16;
    expr(r, 0, 0, 4'b0000, 2'd0);
    expr(r, 1, 4, 4'b0000, 2'd1);
    expr(r, 5, 8, 4'b0001, 2'd1);
    expr(r, 9, 12, 4'b0011, 2'd1);
    expr(r, 13, 14, B, 2'd2);
    to_k(r + 15);
    done = 1'b1;
  end

endmodule

// File: doc/ro_heater_ctrl.md
Name: ro_heater_ctrl

Overview:
Parametrised controller for banked ring-oscillator heater arrays. It replaces the single global RO enable with per-bank enables, which are:
- staged on and off one bank at a time, to limit supply di/dt;
- duty-cycle modulated while running, for thermal power control.
It also includes a gated edge counter that measures one sense RO, for on-die temperature/voltage tracking. It sits between the UART command block (start/mask/duty) and the RO bank arrays.

Parameters:
NUM_BANKS, 8, number of independently enabled RO banks (1..64)
RAMP_CYCLES, 1024, clk cycles between successive bank enable/disable steps (>=2)
PWM_PERIOD, 256, PWM period in clk cycles (>=2)
DUTY_W, 9, width of duty input; must satisfy 2^DUTY_W > PWM_PERIOD
GATE_CYCLES, 65536, frequency-measurement window length in clk cycles (>=2)
CNT_W, 24, width of the RO edge counter / freq_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; 1 = heat, 0 = stop
bank_mask  in  NUM_BANKS  banks to use; latched on leaving IDLE
duty  in  DUTY_W  on-cycles per PWM period; sampled live
ro_sense  in  1  asynchronous sense-RO output
bank_en  out  NUM_BANKS  per-bank RO enables
busy  out  1  1 whenever state != IDLE
state_o  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
freq_count  out  CNT_W  rising edges of ro_sense counted in the last complete window
freq_valid  out  1  one-cycle pulse when freq_count updates

Behaviour:
- Reset (async assert, sync release): state=IDLE, stage_vec=0, mask_q=0, ramp timer=0, pwm_cnt=0. Outputs: bank_en=0, busy=0, state_o=0, freq_count=0, freq_valid=0, sync flops=0, window counter=0, edge counter=0.
- stage_vec: registered set of banks currently staged on.
- Gate signal: gate=1 in all states except RUN; in RUN, gate=(pwm_cnt < duty).
- bank_en = stage_vec AND {NUM_BANKS{gate}}. bank_en is only ever a subset of mask_q.
- IDLE:
  - start=1 and bank_mask!=0 → RAMP_UP next cycle. mask_q<=bank_mask, timer<=0, stage_vec stays 0.
  - start=1 with bank_mask==0 → remain IDLE.
- RAMP_UP:
  - timer increments each cycle. At timer==RAMP_CYCLES-1: timer<=0, and the lowest set bit of (mask_q & ~stage_vec) is set in stage_vec.
  - The first bank turns on RAMP_CYCLES cycles after entry.
  - If that step makes stage_vec==mask_q → RUN on the same edge, pwm_cnt<=0.
  - start=0 at any cycle → RAMP_DOWN next cycle, timer<=0, stage_vec retained.
- RUN:
  - pwm_cnt counts 0..PWM_PERIOD-1, then wraps.
  - duty=0 → banks off all period. duty>=PWM_PERIOD → banks always on.
  - A duty change takes effect on the next cycle's compare.
  - start=0 → RAMP_DOWN next cycle, timer<=0.
  - bank_mask changes are ignored until the next IDLE exit.
- RAMP_DOWN:
  - gate=1 (full on while staging down).
  - At timer==RAMP_CYCLES-1, the highest set bit of stage_vec is cleared.
  - stage_vec becoming 0 → IDLE on the same edge.
  - If stage_vec is already 0 on entry (stop before the first step) → IDLE next cycle.
  - start is ignored until IDLE is reached.
- Frequency monitor (independent of state, runs from reset release):
  - ro_sense passes through a 2-FF synchronizer. A rising edge is detected as sync2 & ~sync3.
  - Window counter counts 0..GATE_CYCLES-1. The edge counter increments on each detected edge and saturates at 2^CNT_W-1.
  - On the last window cycle: freq_count <= edge count, including an edge detected in that cycle. freq_valid=1 for that one cycle. Edge counter cleared to 0.
  - Valid measurement is limited to ro_sense < clk/2. Faster inputs alias; this is documented, not detected.
- Reset mid-operation: all banks off immediately (async), state returns to IDLE.

Test Plan:
- NUM_BANKS=4, RAMP_CYCLES=4, mask=4'b1011, start=1 at cycle 0 → bank_en 0001 at cycle 5, 0011 at cycle 9, 1011 at cycle 13; state_o=2 from cycle 13.
- In RUN, PWM_PERIOD=8: duty=3 → bank_en=1011 for 3 of every 8 cycles. duty=0 → always 0000. duty=8 → always 1011.
- start=0 in RUN → state 3 next cycle, bank_en full 1011. Banks cleared highest-first (1000 cleared, then 0010, then 0001) every 4 cycles; state_o=0 and busy=0 once bank_en=0000.
- Ramp interrupt: start=0 at cycle 10 of the first scenario (0011 on) → RAMP_DOWN; 0001 after 4 cycles, 0000 and IDLE after 8 cycles. mask=0 with start=1 → stays IDLE, bank_en=0.
- GATE_CYCLES=100, ro_sense toggling with period 10 clk → freq_valid pulse every 100 cycles, freq_count=10 (±1 on the first window after reset). CNT_W=3 with 20 edges per window → freq_count=7 (saturated).
- Assert rst in RUN with banks on → bank_en=0 and state_o=0 asynchronously, before the next clk edge; normal ramp-up after release.
